// File: rtl/dm_pipe.sv
// dm_pipe: word-organised data RAM behind valid/ready request/response handshakes,
// with configurable latency, MIPS address-exception detection and a post-reset clear sweep.
module dm_pipe #(
    parameter int          ADDR_W         = 12,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          LATENCY        = 1,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_width,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_exc
);
    localparam int          DEPTH = 2 ** ADDR_W;
    localparam logic [32:0] LIMIT = 33'(DEPTH) * 33'd4;

    typedef enum logic [1:0] {CLEAR, IDLE, WAIT, RESP} state_t;
    state_t state, state_nx;

    logic [31:0]       dm [DEPTH];
    logic [ADDR_W-1:0] idx, widx_r;
    logic [2:0]        cnt, width_r;
    logic [1:0]        lane_r, exc_r;
    logic              we_r, sign_r;
    logic [29:0]       addr_r;
    logic [31:0]       wdata_r, pc_r, off, word, merged, ldata;
    logic [15:0]       half_v;
    logic [7:0]        byte_v;
    logic              bad, commit;

    assign off    = req_addr - BASE_ADDR;
    // Unsigned offset compare makes addresses below BASE_ADDR wrap high and fail.
    assign bad    = !(req_width == 3'd1 || req_width == 3'd2 || req_width == 3'd4)
                  || (req_width == 3'd4 && req_addr[1:0] != 2'b00)
                  || (req_width == 3'd2 && req_addr[0])
                  || ({1'b0, off} >= LIMIT);
    assign commit = state == WAIT && cnt == 3'd0;
    assign word   = dm[widx_r];

    assign req_ready  = reset && state == IDLE;
    assign resp_valid = state == RESP;

    always_comb begin
        merged = word;
        if (width_r == 3'd4)
            merged = wdata_r;
        else if (width_r == 3'd2)
            merged[{lane_r[1], 4'b0000} +: 16] = wdata_r[15:0];
        else
            merged[{lane_r, 3'b000} +: 8] = wdata_r[7:0];
        half_v = word[{lane_r[1], 4'b0000} +: 16];
        byte_v = word[{lane_r, 3'b000} +: 8];
        ldata  = width_r == 3'd4 ? word :
                 width_r == 3'd2 ? {{16{sign_r & half_v[15]}}, half_v} :
                                   {{24{sign_r & byte_v[7]}}, byte_v};
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            CLEAR: if (&idx) state_nx = IDLE;
            IDLE:  if (req_valid) state_nx = WAIT;
            WAIT:  if (cnt == 3'd0) state_nx = RESP;
            RESP:  if (resp_ready) state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= CLEAR_ON_RESET ? CLEAR : IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx        <= '0;
            cnt        <= '0;
            we_r       <= 1'b0;
            sign_r     <= 1'b0;
            width_r    <= '0;
            widx_r     <= '0;
            lane_r     <= '0;
            addr_r     <= '0;
            wdata_r    <= '0;
            pc_r       <= '0;
            exc_r      <= '0;
            resp_rdata <= '0;
            resp_exc   <= '0;
        end else begin
            if (state == CLEAR)
                idx <= idx + 1'b1;
            if (state == IDLE && req_valid) begin
                we_r    <= req_we;
                sign_r  <= req_sign;
                width_r <= req_width;
                widx_r  <= off[ADDR_W+1:2];
                lane_r  <= off[1:0];
                addr_r  <= req_addr[31:2];
                wdata_r <= req_wdata;
                pc_r    <= req_pc;
                cnt     <= 3'(LATENCY - 1);
                exc_r   <= bad ? (req_we ? 2'b10 : 2'b01) : 2'b00;
            end
            if (state == WAIT && cnt != 3'd0)
                cnt <= cnt - 1'b1;
            if (commit) begin
                resp_exc   <= exc_r;
                resp_rdata <= (we_r || exc_r != 2'b00) ? 32'd0 : ldata;
            end
        end
    end

    // RAM has no reset; writes are gated so a held reset never commits or sweeps.
    always_ff @(posedge clk) begin
        if (reset && state == CLEAR)
            dm[idx] <= '0;
        if (reset && commit && we_r && exc_r == 2'b00) begin
            dm[widx_r] <= merged;
            $display("%d@%h: *%h <= %h", $time, pc_r, {addr_r, 2'b00}, merged);
        end
    end
endmodule

// File: tb/tb_dm_pipe.sv
// tb_dm_pipe: directed checks of dm_pipe; u0 has LATENCY=1 with clear sweep,
// u1 has LATENCY=3 without clear, both with 16 words.
module tb_dm_pipe;
    logic        clk = 1'b0;
    logic        reset [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we [2];
    logic [2:0]  req_width [2];
    logic        req_sign [2];
    logic [31:0] req_addr [2];
    logic [31:0] req_wdata [2];
    logic [31:0] req_pc [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic [1:0]  resp_exc [2];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    dm_pipe #(.ADDR_W(4), .LATENCY(1), .CLEAR_ON_RESET(1'b1)) u0 (
        .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_width(req_width[0]), .req_sign(req_sign[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_pc(req_pc[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_exc(resp_exc[0])
    );

    dm_pipe #(.ADDR_W(4), .LATENCY(3), .CLEAR_ON_RESET(1'b0)) u1 (
        .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_width(req_width[1]), .req_sign(req_sign[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_pc(req_pc[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_exc(resp_exc[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic issue(input int d, input logic we, input logic [2:0] w, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        int n;
        n = 0;
        while (!req_ready[d] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_timeout", 32'(n >= 100), 32'd0);
        req_we[d]    = we;
        req_width[d] = w;
        req_sign[d]  = sg;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        req_pc[d]    = 32'h0040_0000 + a;
        req_valid[d] = 1'b1;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
    endtask

    task automatic wait_resp(input int d, input string tag);
        int n;
        n = 0;
        while (!resp_valid[d] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_lat"}, n, d == 1 ? 32'd3 : 32'd1);
    endtask

    task automatic xfer(input int d, input string tag, input logic we, input logic [2:0] w,
                        input logic sg, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic [1:0] exp_exc);
        issue(d, we, w, sg, a, wd);
        wait_resp(d, tag);
        chk({tag, "_rdata"}, resp_rdata[d], exp_rd);
        chk({tag, "_exc"}, 32'(resp_exc[d]), 32'(exp_exc));
        @(posedge clk); #1;
        chk({tag, "_vdrop"}, 32'(resp_valid[d]), 32'd0);
        chk({tag, "_rdy"}, 32'(req_ready[d]), 32'd1);
    endtask

    initial begin
        int n;
        for (int d = 0; d < 2; d++) begin
            reset[d]      = 1'b0;
            req_valid[d]  = 1'b0;
            req_we[d]     = 1'b0;
            req_width[d]  = 3'd4;
            req_sign[d]   = 1'b0;
            req_addr[d]   = '0;
            req_wdata[d]  = '0;
            req_pc[d]     = '0;
            resp_ready[d] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready[0]), 32'd0);
        chk("rst_valid", 32'(resp_valid[0]), 32'd0);
        chk("rst_rdata", resp_rdata[0], 32'd0);
        chk("rst_exc", 32'(resp_exc[0]), 32'd0);
        chk("rst_ready_u1", 32'(req_ready[1]), 32'd0);
        reset[0] = 1'b1;
        reset[1] = 1'b1;
        #1;
        chk("u1_ready_now", 32'(req_ready[1]), 32'd1);
        n = 0;
        while (!req_ready[0] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("clear_cycles", n, 32'd16);
        xfer(0, "clr_w5", 1'b0, 3'd4, 1'b0, 32'h14, 32'h0, 32'h0, 2'b00);

        xfer(0, "st_w", 1'b1, 3'd4, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 2'b00);
        xfer(0, "st_b", 1'b1, 3'd1, 1'b0, 32'h12, 32'h0000_0055, 32'h0, 2'b00);
        xfer(0, "ld_w", 1'b0, 3'd4, 1'b0, 32'h10, 32'h0, 32'hDE55_BEEF, 2'b00);
        xfer(0, "ld_hs", 1'b0, 3'd2, 1'b1, 32'h12, 32'h0, 32'hFFFF_DE55, 2'b00);
        xfer(0, "ld_hu", 1'b0, 3'd2, 1'b0, 32'h12, 32'h0, 32'h0000_DE55, 2'b00);
        xfer(0, "ld_bs3", 1'b0, 3'd1, 1'b1, 32'h13, 32'h0, 32'hFFFF_FFDE, 2'b00);
        xfer(0, "ld_bu1", 1'b0, 3'd1, 1'b0, 32'h11, 32'h0, 32'h0000_00BE, 2'b00);
        xfer(0, "ld_bs0", 1'b0, 3'd1, 1'b1, 32'h10, 32'h0, 32'hFFFF_FFEF, 2'b00);
        xfer(0, "ld_hl0", 1'b0, 3'd2, 1'b1, 32'h10, 32'h0, 32'hFFFF_BEEF, 2'b00);
        xfer(0, "st_h0", 1'b1, 3'd2, 1'b0, 32'h18, 32'hAAAA_1234, 32'h0, 2'b00);
        xfer(0, "ld_h0w", 1'b0, 3'd4, 1'b0, 32'h18, 32'h0, 32'h0000_1234, 2'b00);

        xfer(0, "ades_mis", 1'b1, 3'd4, 1'b0, 32'h02, 32'hFFFF_FFFF, 32'h0, 2'b10);
        xfer(0, "ades_keep", 1'b0, 3'd4, 1'b0, 32'h00, 32'h0, 32'h0, 2'b00);
        xfer(0, "adel_oor", 1'b0, 3'd4, 1'b0, 32'h40, 32'h0, 32'h0, 2'b01);
        xfer(0, "adel_last", 1'b0, 3'd4, 1'b0, 32'h3C, 32'h0, 32'h0, 2'b00);
        xfer(0, "adel_w3", 1'b0, 3'd3, 1'b0, 32'h10, 32'h0, 32'h0, 2'b01);
        xfer(0, "ades_w3", 1'b1, 3'd3, 1'b0, 32'h10, 32'h1111_1111, 32'h0, 2'b10);
        xfer(0, "adel_h1", 1'b0, 3'd2, 1'b0, 32'h11, 32'h0, 32'h0, 2'b01);
        xfer(0, "ades_neg", 1'b1, 3'd1, 1'b0, 32'hFFFF_FFFC, 32'h77, 32'h0, 2'b10);
        xfer(0, "keep_w", 1'b0, 3'd4, 1'b0, 32'h10, 32'h0, 32'hDE55_BEEF, 2'b00);

        xfer(1, "u1_st", 1'b1, 3'd4, 1'b0, 32'h20, 32'h1234_5678, 32'h0, 2'b00);
        resp_ready[1] = 1'b0;
        issue(1, 1'b0, 3'd4, 1'b0, 32'h20, 32'h0);
        wait_resp(1, "bp");
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", 32'(resp_valid[1]), 32'd1);
            chk("bp_rdata", resp_rdata[1], 32'h1234_5678);
            chk("bp_noready", 32'(req_ready[1]), 32'd0);
            @(posedge clk); #1;
        end
        chk("bp_hold", 32'(resp_valid[1]), 32'd1);
        resp_ready[1] = 1'b1;
        @(posedge clk); #1;
        chk("bp_drop", 32'(resp_valid[1]), 32'd0);
        chk("bp_rdy", 32'(req_ready[1]), 32'd1);

        issue(1, 1'b1, 3'd4, 1'b0, 32'h20, 32'hAAAA_AAAA);
        reset[1] = 1'b0;
        #1;
        chk("rw_valid", 32'(resp_valid[1]), 32'd0);
        chk("rw_ready", 32'(req_ready[1]), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("rw_quiet", 32'(resp_valid[1]), 32'd0);
        reset[1] = 1'b1;
        #1;
        xfer(1, "rw_keep", 1'b0, 3'd4, 1'b0, 32'h20, 32'h0, 32'h1234_5678, 2'b00);

        resp_ready[1] = 1'b0;
        issue(1, 1'b0, 3'd4, 1'b0, 32'h20, 32'h0);
        wait_resp(1, "rr");
        chk("rr_rdata", resp_rdata[1], 32'h1234_5678);
        reset[1] = 1'b0;
        #1;
        chk("rr_valid", 32'(resp_valid[1]), 32'd0);
        chk("rr_rdata0", resp_rdata[1], 32'd0);
        @(posedge clk); #1;
        reset[1] = 1'b1;
        resp_ready[1] = 1'b1;
        #1;
        chk("rr_ready", 32'(req_ready[1]), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
